// File: rtl/unary_operand_feeder_if.sv
// Operand handshake and unary stream bundle between the operand source, the feeder and the unary adder.
interface unary_operand_feeder_if #(
    parameter int unsigned WIDTH = 10
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             ready;
    logic             a_out;
    logic             b_out;
    logic             en_out;
    logic             read_or_write_out;
    logic             done;

    modport master (
        output start, op_a, op_b,
        input  ready, a_out, b_out, en_out, read_or_write_out, done
    );

    modport slave (
        input  start, op_a, op_b,
        output ready, a_out, b_out, en_out, read_or_write_out, done
    );
endinterface

// File: rtl/unary_operand_feeder.sv
// Converts two binary operands into parallel unary pulse trains for the unary adder, then opens a read window.
// Optional UNARY_FEEDER_ABORT_EN adds an abort input that cancels a transaction in EMIT or READ.
module unary_operand_feeder #(
    parameter int unsigned WIDTH       = 10,
    parameter int unsigned READ_CYCLES = 20
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef UNARY_FEEDER_ABORT_EN
    input  logic                 abort,
`endif
    unary_operand_feeder_if.slave bus
);
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {IDLE, EMIT, READ, FIN} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] ra, ra_d;
    logic [WIDTH-1:0] rb, rb_d;
    logic             phase, phase_d;   // 0 = high slot, 1 = low slot
    logic [CW-1:0]    rcnt, rcnt_d;

    logic ready_q, a_q, b_q, en_q, rw_q, done_q;
    logic ready_d, a_d, b_d, en_d, rw_d, done_d;
    logic abort_c;

`ifdef UNARY_FEEDER_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ra      <= '0;
            rb      <= '0;
            phase   <= 1'b0;
            rcnt    <= '0;
            ready_q <= 1'b1;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            en_q    <= 1'b0;
            rw_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_d;
            ra      <= ra_d;
            rb      <= rb_d;
            phase   <= phase_d;
            rcnt    <= rcnt_d;
            ready_q <= ready_d;
            a_q     <= a_d;
            b_q     <= b_d;
            en_q    <= en_d;
            rw_q    <= rw_d;
            done_q  <= done_d;
        end
    end

    // Next state; outputs are derived from the next state so they appear registered
    always_comb begin
        state_d = state;
        ra_d    = ra;
        rb_d    = rb;
        phase_d = phase;
        rcnt_d  = rcnt;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    ra_d    = bus.op_a;
                    rb_d    = bus.op_b;
                    phase_d = 1'b0;
                    if ((bus.op_a == '0) && (bus.op_b == '0)) begin
                        state_d = READ;
                        rcnt_d  = CW'(READ_CYCLES - 1);
                    end else begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (!phase) begin
                    phase_d = 1'b1;
                end else begin
                    // Low slot closes one unit on each stream still owing pulses
                    phase_d = 1'b0;
                    ra_d    = ra - WIDTH'(ra != '0);
                    rb_d    = rb - WIDTH'(rb != '0);
                    if ((ra_d == '0) && (rb_d == '0)) begin
                        state_d = READ;
                        rcnt_d  = CW'(READ_CYCLES - 1);
                    end
                end
            end
            READ: begin
                if (rcnt == '0) begin
                    state_d = FIN;
                end else begin
                    rcnt_d = rcnt - CW'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_c && ((state == EMIT) || (state == READ))) begin
            state_d = IDLE;
            ra_d    = '0;
            rb_d    = '0;
            phase_d = 1'b0;
            rcnt_d  = '0;
        end

        ready_d = (state_d == IDLE);
        en_d    = (state_d == EMIT) || (state_d == READ);
        rw_d    = (state_d == READ);
        done_d  = (state_d == FIN);
        a_d     = (state_d == EMIT) && !phase_d && (ra_d != '0);
        b_d     = (state_d == EMIT) && !phase_d && (rb_d != '0);
    end

    assign bus.ready             = ready_q;
    assign bus.a_out             = a_q;
    assign bus.b_out             = b_q;
    assign bus.en_out            = en_q;
    assign bus.read_or_write_out = rw_q;
    assign bus.done              = done_q;
endmodule

// File: tb/tb_unary_operand_feeder.sv
// Scoreboard bench for unary_operand_feeder: the model queues the expected per-cycle outputs of each accepted
// transaction, and a negedge monitor pops and compares every cycle.
module tb_unary_operand_feeder;
    localparam int unsigned WIDTH = 10;
    localparam int unsigned RC    = 20;

    typedef struct packed {
        logic ready;
        logic a;
        logic b;
        logic en;
        logic rw;
        logic done;
    } vec_t;

    localparam vec_t IDLE_V = '{ready: 1'b1, a: 1'b0, b: 1'b0, en: 1'b0, rw: 1'b0, done: 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef UNARY_FEEDER_ABORT_EN
    logic abort = 1'b0;
`endif

    always #5 clk = ~clk;

    unary_operand_feeder_if #(.WIDTH(WIDTH)) bus ();

    unary_operand_feeder #(
        .WIDTH(WIDTH),
        .READ_CYCLES(RC)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef UNARY_FEEDER_ABORT_EN
        .abort(abort),
`endif
        .bus(bus)
    );

    vec_t exp_q[$];
    vec_t cur = IDLE_V;
    int   acc_cnt     = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic vec_t mk(input bit r, input bit a, input bit b, input bit en, input bit rw, input bit d);
        vec_t v;
        v.ready = r; v.a = a; v.b = b; v.en = en; v.rw = rw; v.done = d;
        return v;
    endfunction

    function automatic string vname(input vec_t v);
        if (v.done) return "done";
        if (v.rw)   return "read";
        if (v.en)   return "emit";
        return "idle";
    endfunction

    // Expected trace of one transaction: unit n is a high slot then a low slot, pulses while n < operand
    task automatic push_txn(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        for (int unsigned i = 0; i < 2 * m; i++) begin
            bit hi;
            hi = (i % 2 == 0);
            exp_q.push_back(mk(1'b0, hi && ((i / 2) < a), hi && ((i / 2) < b), 1'b1, 1'b0, 1'b0));
        end
        repeat (RC) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(IDLE_V);
    endtask

    // Reference model: accepts only when nothing is outstanding
    always @(posedge clk or posedge rst) begin
        bit idle;
        if (rst) begin
            exp_q.delete();
        end else begin
            idle = (exp_q.size() == 0);
`ifdef UNARY_FEEDER_ABORT_EN
            if (abort && cur.en) exp_q.delete();
`endif
            if (idle && bus.start) begin
                push_txn(int'(bus.op_a), int'(bus.op_b));
                acc_cnt++;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        vec_t e;
        vec_t got;
        got = mk(bus.ready, bus.a_out, bus.b_out, bus.en_out, bus.read_or_write_out, bus.done);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = IDLE_V;
        cur = e;
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%b required=%b (ready,a,b,en,rw,done)", vname(e), $time, got, e);
        end
    end

    task automatic bound_check(input bit ok, input string name);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s t=%0t got=timeout required=event", name, $time);
        end
    endtask

    task automatic start_txn(input int unsigned a, input int unsigned b);
        int base;
        bit ok;
        base = acc_cnt;
        ok   = 1'b0;
        bus.op_a  = WIDTH'(a);
        bus.op_b  = WIDTH'(b);
        bus.start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (acc_cnt != base) begin ok = 1'b1; break; end
        end
        bus.start = 1'b0;
        bus.op_a  = WIDTH'($urandom);
        bus.op_b  = WIDTH'($urandom);
        bound_check(ok, "accept");
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        bound_check(ok, "drain");
    endtask

    task automatic run(input int unsigned a, input int unsigned b);
        start_txn(a, b);
        wait_drain();
    endtask

    initial begin
        int base;
        bit ok;
        vec_t got;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run(3, 1);
        run(0, 0);
        run(513, 513);
        run(1023, 0);
        run(0, 7);
        run(1, 1);

        // start held high across three transactions
        base = acc_cnt;
        ok   = 1'b0;
        bus.op_a  = WIDTH'($urandom_range(0, 6));
        bus.op_b  = WIDTH'($urandom_range(0, 6));
        bus.start = 1'b1;
        for (int i = 0; i < 500; i++) begin
            int prev;
            prev = acc_cnt;
            @(posedge clk); #1;
            if (acc_cnt != prev) begin
                bus.op_a = WIDTH'($urandom_range(0, 6));
                bus.op_b = WIDTH'($urandom_range(0, 6));
            end
            if (acc_cnt == base + 3) begin ok = 1'b1; break; end
        end
        bus.start = 1'b0;
        bound_check(ok, "held_start");
        wait_drain();

        // asynchronous reset in the middle of EMIT
        start_txn(10, 0);
        repeat (5) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        got = mk(bus.ready, bus.a_out, bus.b_out, bus.en_out, bus.read_or_write_out, bus.done);
        vectors++;
        if (got !== IDLE_V) begin
            miscompares++;
            $display("FAIL async_rst t=%0t got=%b required=%b", $time, got, IDLE_V);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        run(4, 2);

`ifdef UNARY_FEEDER_ABORT_EN
        // abort sampled on the edge ending the 4th EMIT cycle
        start_txn(10, 5);
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_drain();
        // abort during READ
        start_txn(0, 0);
        repeat (6) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_drain();
        // abort in IDLE is harmless, and start wins when both arrive together
        abort = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start_txn(2, 3);
        abort = 1'b0;
        wait_drain();
`endif

        for (int n = 0; n < 20; n++) begin
            run($urandom_range(0, 40), $urandom_range(0, 40));
        end

        repeat (4) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/unary_operand_feeder.md
# unary_operand_feeder

Sequencer directly upstream of the 10-bit unary adder. It accepts two binary operands through a start/ready handshake and drives the adder's inputs:
- converts each operand into a unary pulse train on `a_out` / `b_out`, one high cycle followed by one low cycle per unit, both trains in parallel;
- holds the adder enabled throughout;
- switches the adder into read mode for a fixed window, then signals completion.

## Interface
- `WIDTH`, 10, operand width; matches the adder's counter width.
- `READ_CYCLES`, 20, number of cycles `read_or_write_out` is held high; legal range 1 to 2^16-1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only on an edge where `ready`=1.
- `op_a`  in  WIDTH  operand A; sampled on the accept edge.
- `op_b`  in  WIDTH  operand B; sampled on the accept edge.
- `ready`  out  1  high only in IDLE.
- `a_out`  out  1  unary stream to adder input A.
- `b_out`  out  1  unary stream to adder input B.
- `en_out`  out  1  adder enable.
- `read_or_write_out`  out  1  0 = accumulate, 1 = read out.
- `done`  out  1  one-cycle pulse at the end of a transaction.

## Operation
- States: IDLE, EMIT, READ, FIN.
- IDLE:
  - `ready`=1; all other outputs 0.
  - When `start`=1 on an edge: latch `op_a`/`op_b` into down-counters `ra`/`rb` and clear the phase bit.
  - If `op_a`=`op_b`=0, go to READ; otherwise go to EMIT.
- EMIT:
  - `en_out`=1.
  - The phase bit toggles every cycle.
  - High phase: `a_out`=(`ra`≠0), `b_out`=(`rb`≠0).
  - Low phase: both outputs 0, and each nonzero counter decrements by 1.
  - Leave for READ on the low-phase edge where both counters reach 0.
  - A 0 operand produces no pulses on its stream; the other stream continues unaffected.
- READ:
  - `en_out`=1, `read_or_write_out`=1, `a_out`=`b_out`=0.
  - A cycle counter loads READ_CYCLES-1 on entry; go to FIN when it hits 0.
- FIN: `done`=1 and `en_out`=0 for one cycle, then IDLE.
- `start` outside IDLE is ignored and is not queued.
- Arithmetic: counters are WIDTH bits and decrement-only, so no wrap is possible. The sum `op_a`+`op_b` may exceed 2^WIDTH-1; the adder's carry handles that, and the feeder does not check it.
- All outputs are registered; none are combinational from inputs.

## Timing
- Reset (asynchronous, takes effect immediately and applies mid-transaction too):
  - State = IDLE.
  - `ready`=1.
  - `a_out`, `b_out`, `en_out`, `read_or_write_out`, `done` = 0.
  - Counters cleared.
- Accept edge k, with M = max(`op_a`, `op_b`):
  - The first high phase is visible in the cycle after edge k.
  - EMIT occupies cycles k+1 … k+2M.
  - READ occupies cycles k+2M+1 … k+2M+READ_CYCLES.
  - `done` is high in cycle k+2M+READ_CYCLES+1.
  - `ready`=1 from cycle k+2M+READ_CYCLES+2.
- Back-to-back: a `start` sampled on the first IDLE edge is accepted, so the minimum inter-transaction gap is one IDLE cycle.
- Both operands zero: EMIT is skipped (M=0 timing above).
- `op_a`=2^WIDTH-1 (1023): 1023 pulses on `a_out`, EMIT lasts 2046 cycles.

## Configuration
- `UNARY_FEEDER_ABORT_EN` defined:
  - Adds input port `abort` (1 bit).
  - `abort`=1 on an edge in EMIT or READ: next state IDLE, all outputs 0, `ready`=1, and no `done` pulse.
  - `abort` in IDLE or FIN has no effect.
  - `abort` and `start` together in IDLE: `start` wins.
- Macro undefined: the port is absent and transactions always run to FIN.

## Test plan
- Reset, then `op_a`=3, `op_b`=1, `start` pulse, READ_CYCLES=20 -> `a_out` high exactly 3 cycles, `b_out` exactly 1 cycle, both only in the first phase slot pattern; `read_or_write_out` high 20 cycles; `done` 6+20+1 cycles after accept.
- `op_a`=`op_b`=0 -> no pulses on either stream; READ starts the cycle after accept; `done` at cycle 21.
- `op_a`=513, `op_b`=513 with the adder attached -> 513 pulses on each stream; the adder reports count 2 (1026 mod 1024) with C=1 in READ.
- `start` held high continuously for 3 transactions -> each accepted only from IDLE; exactly one `done` per transaction; one IDLE cycle between transactions.
- Assert `rst` mid-EMIT at `op_a`=10 -> all outputs 0 and `ready`=1 immediately (before the next edge); the next `start` behaves as from power-on.
- With `UNARY_FEEDER_ABORT_EN`: `abort` at the 4th cycle of EMIT -> outputs 0 the next cycle, no `done`; without the macro, the bench compiles without `abort`.
